// File: rtl/tdp_ram_pipe.sv
// tdp_ram_pipe: single-clock true dual-port RAM, byte enables,
// pipelined reads with valid strobes. Option: TDP_RAM_ZERO_INIT_EN.
module tdp_ram_pipe #(
  parameter int DATA_WIDTH = 20,
  parameter int BYTE_W     = 10,
  parameter int ADDR_WIDTH = 7,
  parameter int MEM_SIZE   = 128,
  parameter int RD_LATENCY = 2,
  parameter int WRITE_MODE = 0,
  localparam int NB        = DATA_WIDTH / BYTE_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_a,
  input  logic [NB-1:0]         we_a,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [DATA_WIDTH-1:0] din_a,
  output logic [DATA_WIDTH-1:0] dout_a,
  output logic                  rvalid_a,
  input  logic                  en_b,
  input  logic [NB-1:0]         we_b,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] din_b,
  output logic [DATA_WIDTH-1:0] dout_b,
  output logic                  rvalid_b,
  output logic                  collision,
  output logic                  init_busy
);

  logic [DATA_WIDTH-1:0] r_mem [MEM_SIZE];

  logic [1:0]            w_en;
  logic [NB-1:0]         w_we   [2];
  logic [ADDR_WIDTH-1:0] w_addr [2];
  logic [DATA_WIDTH-1:0] w_din  [2];
  logic [DATA_WIDTH-1:0] w_dout [2];
  logic [1:0]            w_rvalid;
  logic [1:0]            w_wr;
  logic                  w_busy;
  logic                  w_sweep;
  logic [ADDR_WIDTH-1:0] w_init_addr;
  logic                  r_col;

  function automatic logic [DATA_WIDTH-1:0] f_merge(
    input logic [DATA_WIDTH-1:0] old_w,
    input logic [DATA_WIDTH-1:0] new_w,
    input logic [NB-1:0]         be
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_w;
    for (int b = 0; b < NB; b++)
      if (be[b])
        res[b*BYTE_W +: BYTE_W] = new_w[b*BYTE_W +: BYTE_W];
    return res;
  endfunction

  assign w_en      = {en_b, en_a};
  assign w_we[0]   = we_a;
  assign w_we[1]   = we_b;
  assign w_addr[0] = addr_a;
  assign w_addr[1] = addr_b;
  assign w_din[0]  = din_a;
  assign w_din[1]  = din_b;

`ifdef TDP_RAM_ZERO_INIT_EN
  logic [ADDR_WIDTH-1:0] r_init_cnt;
  logic                  r_init_done;

  // Zero sweep counter; restarts from address 0 after every reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_init_cnt  <= '0;
      r_init_done <= 1'b0;
    end else if (!r_init_done) begin
      r_init_cnt <= r_init_cnt + ADDR_WIDTH'(1);
      if (int'(r_init_cnt) == MEM_SIZE - 1)
        r_init_done <= 1'b1;
    end
  end

  assign w_busy      = ~r_init_done;
  assign w_init_addr = r_init_cnt;
`else
  assign w_busy      = 1'b0;
  assign w_init_addr = '0;
`endif

  assign w_sweep   = ~rst & w_busy;
  assign init_busy = w_sweep;

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic                  w_acc;
    logic                  w_inr;
    logic                  w_rv;
    logic [DATA_WIDTH-1:0] w_old;
    logic [DATA_WIDTH-1:0] w_rd;
    logic                  r_v0;
    logic                  r_v1;
    logic [DATA_WIDTH-1:0] r_d0;
    logic [DATA_WIDTH-1:0] r_d1;

    assign w_acc = w_en[p] & ~rst & ~w_busy;
    assign w_inr = int'(w_addr[p]) < MEM_SIZE;
    assign w_wr[p] = w_acc & w_inr & (|w_we[p]);
    assign w_old = w_inr ? r_mem[w_addr[p]] : '0;
    assign w_rv = w_acc &
                  ~((WRITE_MODE == 2) & (|w_we[p]));
    assign w_rd = (WRITE_MODE == 1 && w_wr[p]) ?
                  f_merge(w_old, w_din[p], w_we[p]) : w_old;

    // RAM read register then data register; data holds when idle.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_v0 <= 1'b0;
        r_v1 <= 1'b0;
        r_d0 <= '0;
        r_d1 <= '0;
      end else begin
        r_v0 <= w_rv;
        r_v1 <= r_v0;
        if (w_rv) r_d0 <= w_rd;
        if (r_v0) r_d1 <= r_d0;
      end
    end

    if (RD_LATENCY == 2) begin : g_l2
      logic                  r_v2;
      logic [DATA_WIDTH-1:0] r_d2;

      // Extra output register stage.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_v2 <= 1'b0;
          r_d2 <= '0;
        end else begin
          r_v2 <= r_v1;
          if (r_v1) r_d2 <= r_d1;
        end
      end

      assign w_dout[p]   = r_d2;
      assign w_rvalid[p] = r_v2;
    end else begin : g_l1
      assign w_dout[p]   = r_d1;
      assign w_rvalid[p] = r_v1;
    end
  end

  // Memory write: port B first so port A wins shared bytes.
  always_ff @(posedge clk) begin
    if (w_sweep)
      r_mem[w_init_addr] <= '0;
    for (int b = 0; b < NB; b++) begin
      if (w_wr[1] && w_we[1][b])
        r_mem[w_addr[1]][b*BYTE_W +: BYTE_W] <=
          w_din[1][b*BYTE_W +: BYTE_W];
      if (w_wr[0] && w_we[0][b])
        r_mem[w_addr[0]][b*BYTE_W +: BYTE_W] <=
          w_din[0][b*BYTE_W +: BYTE_W];
    end
  end

  // Flag both ports writing the same in-range word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_col <= 1'b0;
    else     r_col <= w_wr[0] & w_wr[1] &
                      (addr_a == addr_b);
  end

  assign dout_a    = w_dout[0];
  assign dout_b    = w_dout[1];
  assign rvalid_a  = w_rvalid[0];
  assign rvalid_b  = w_rvalid[1];
  assign collision = r_col;

endmodule
